fft16_radix4_seq: RTL and testbench

FFT16_RADIX4_SEQ -- requirements
Module: fft16_radix4_seq

---
 rtl/fft16_pkg.sv | 55 +++++
 rtl/fft16_radix4_seq_tag_delay.sv | 37 +++
 rtl/fft16_radix4_seq.sv | 157 +++++++++++++++
 tb/tb_fft16_radix4_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// ---------------------------------------------------------------------------
// fft16_pkg -- shared constants, types and address helpers for the 16-point
// radix-4 FFT sequencer.
//
// Contents:
//   N, RADIX, ADDR_W, TW_W        transform geometry
//   state_t                       sequencer FSM encoding
//   tag_t                         write-back tag {valid, stage, n}
//   strided_addr / block_addr     four-sample address sets {a3,a2,a1,a0}
//   tw_set                        stage-2 twiddle indices {k2,k1,k0}
// ---------------------------------------------------------------------------
package fft16_pkg;

    localparam int N      = 16;
    localparam int RADIX  = 4;
    localparam int ADDR_W = 4;
    localparam int TW_W   = 4;
    localparam int N_W    = $clog2(N / RADIX);   // butterfly index width

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE1 = 3'd1,
        S_DRAIN1 = 3'd2,
        S_ISSUE2 = 3'd3,
        S_DRAIN2 = 3'd4
    } state_t;

    typedef struct packed {
        logic           valid;
        logic           stage;  // 0: stage 1, 1: stage 2
        logic [N_W-1:0] n;
    } tag_t;

    // {n+12, n+8, n+4, n}: samples spaced a quarter-transform apart.
    function automatic logic [RADIX*ADDR_W-1:0] strided_addr(input logic [N_W-1:0] n);
        logic [ADDR_W-1:0] b;
        b = {{(ADDR_W-N_W){1'b0}}, n};
        return {b + 4'd12, b + 4'd8, b + 4'd4, b};
    endfunction

    // {4n+3, 4n+2, 4n+1, 4n}: four consecutive samples.
    function automatic logic [RADIX*ADDR_W-1:0] block_addr(input logic [N_W-1:0] n);
        logic [ADDR_W-1:0] b;
        b = {n, 2'b00};
        return {b + 4'd3, b + 4'd2, b + 4'd1, b};
    endfunction

    // {3n, 2n, n}: twiddle exponents of W16 for the three non-trivial legs.
    function automatic logic [3*TW_W-1:0] tw_set(input logic [N_W-1:0] n);
        logic [TW_W-1:0] k;
        k = {{(TW_W-N_W){1'b0}}, n};
        return {k + k + k, k + k, k};
    endfunction

endpackage

// File: rtl/fft16_radix4_seq_tag_delay.sv
// ---------------------------------------------------------------------------
// fft_tag_delay -- fixed-depth delay line carrying the write-back tag of each
// issued butterfly so the write happens exactly DEPTH cycles after the read.
//
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset, empties the line
//   tag_in   tag entering this cycle (valid=0 when nothing issued)
//   tag_out  tag issued DEPTH cycles ago
// ---------------------------------------------------------------------------
module fft_tag_delay
    import fft16_pkg::*;
#(
    parameter int DEPTH = 9
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t pipe_q [DEPTH];

    // NOTE: every entry is reset, not just the head; a stale valid bit left in
    // the line would fire a write after an aborted transform.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft16_radix4_seq.sv
// ---------------------------------------------------------------------------
// fft16_radix4_seq -- control sequencer for a 16-point radix-4 FFT built from
// one pipelined 4-point butterfly. Two stages of four butterflies each; stage 1
// reads bank 0 and writes bank 1, stage 2 reads bank 1 and writes bank 0.
//
// Parameters:
//   BFLY_LAT  butterfly input-to-output latency (cycles)
//   RD_LAT    sample-RAM / twiddle-ROM read latency (cycles)
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   start             request a transform (sampled in IDLE only)
//   hold              stalls butterfly issue in ISSUE states
//   busy, done        busy from acceptance to done; done is a 1-cycle pulse
//   rd_en/addr/bank   four-sample read request, addr = {a3,a2,a1,a0}
//   tw_idx            twiddle indices {k2,k1,k0}, valid with rd_en
//   wr_en/addr/bank   write-back of butterfly outputs p1..p4
//   stage             0 during stage 1, 1 during stage 2
//   cycle_cnt         (only with FFT_SEQ_CYCLE_CNT_EN) transform cycle count
// ---------------------------------------------------------------------------
module fft16_radix4_seq
    import fft16_pkg::*;
#(
    parameter int BFLY_LAT = 8,
    parameter int RD_LAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    hold,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [RADIX*ADDR_W-1:0] rd_addr,
    output logic                    rd_bank,
    output logic [3*TW_W-1:0]       tw_idx,
    output logic                    wr_en,
    output logic [RADIX*ADDR_W-1:0] wr_addr,
    output logic                    wr_bank,
    output logic                    stage
`ifdef FFT_SEQ_CYCLE_CNT_EN
    ,
    output logic [7:0]              cycle_cnt
`endif
);

    localparam int PIPE = RD_LAT + BFLY_LAT;

    state_t                  state_q, state_d;
    logic [N_W-1:0]          n_q;
    logic                    issue;
    logic                    issue_stage;
    logic                    done_q, done_d;
    logic                    last_wr;
    logic [RADIX*ADDR_W-1:0] rd_addr_now, rd_addr_q;
    logic [RADIX*ADDR_W-1:0] wr_addr_now, wr_addr_q;
    logic [3*TW_W-1:0]       tw_now, tw_q;
    logic                    rd_bank_q, wr_bank_q;
    tag_t                    tag_in, tag_out;

    // Issue is decided in the same cycle hold is seen, so a stall takes
    // effect immediately rather than one cycle late.
    assign issue_stage = (state_q == S_ISSUE2);
    assign last_wr     = tag_out.valid && (tag_out.n == N_W'(RADIX - 1));

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_ISSUE1;
            S_ISSUE1, S_ISSUE2: begin
                if (!hold) begin
                    issue = 1'b1;
                    if (n_q == N_W'(RADIX - 1))
                        state_d = issue_stage ? S_DRAIN2 : S_DRAIN1;
                end
            end
            // Next stage may not read until the last write of this one lands.
            S_DRAIN1: if (last_wr) state_d = S_ISSUE2;
            S_DRAIN2: begin
                if (last_wr) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    assign rd_addr_now = issue_stage ? block_addr(n_q) : strided_addr(n_q);
    assign tw_now      = issue_stage ? tw_set(n_q) : '0;
    assign wr_addr_now = tag_out.stage ? strided_addr(tag_out.n) : block_addr(tag_out.n);

    assign tag_in = '{valid: issue, stage: issue_stage, n: n_q};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            done_q    <= 1'b0;
            rd_addr_q <= '0;
            tw_q      <= '0;
            rd_bank_q <= 1'b0;
            wr_addr_q <= '0;
            wr_bank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (issue) begin
                n_q       <= n_q + 1'b1;   // wraps to 0 after n=3, ready for next stage
                rd_addr_q <= rd_addr_now;
                tw_q      <= tw_now;
                rd_bank_q <= issue_stage;
            end
            if (tag_out.valid) begin
                wr_addr_q <= wr_addr_now;
                wr_bank_q <= ~tag_out.stage;
            end
        end
    end

    fft_tag_delay #(.DEPTH(PIPE)) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Address outputs show the live request when enabled, else the last one.
    assign rd_en   = issue;
    assign rd_addr = issue ? rd_addr_now : rd_addr_q;
    assign tw_idx  = issue ? tw_now      : tw_q;
    assign rd_bank = issue ? issue_stage : rd_bank_q;
    assign wr_en   = tag_out.valid;
    assign wr_addr = tag_out.valid ? wr_addr_now    : wr_addr_q;
    assign wr_bank = tag_out.valid ? ~tag_out.stage : wr_bank_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign stage   = (state_q == S_ISSUE2) || (state_q == S_DRAIN2);

`ifdef FFT_SEQ_CYCLE_CNT_EN
    // Counts from the first busy cycle through the done cycle, then holds.
    logic [7:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst)                           cnt_q <= '0;
        else if (state_q == S_IDLE && start) cnt_q <= '0;
        else if (busy || done_q)           cnt_q <= cnt_q + 8'd1;
    end
    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fft16_radix4_seq.sv
// ---------------------------------------------------------------------------
// tb_fft16_radix4_seq -- scoreboard bench for fft16_radix4_seq
// (BFLY_LAT=8, RD_LAT=1). Stimulus pushes expected read/write/done events;
// a negedge monitor pops and compares whenever the DUT presents one.
// ---------------------------------------------------------------------------
module tb_fft16_radix4_seq;

    logic        clk = 1'b0;
    logic        rst, start, hold;
    logic        busy, done, rd_en, rd_bank, wr_en, wr_bank, stage;
    logic [15:0] rd_addr, wr_addr;
    logic [11:0] tw_idx;
`ifdef FFT_SEQ_CYCLE_CNT_EN
    logic [7:0]  cycle_cnt;
`endif

    fft16_radix4_seq #(.BFLY_LAT(8), .RD_LAT(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .hold    (hold),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_bank (rd_bank),
        .tw_idx  (tw_idx),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_bank (wr_bank),
        .stage   (stage)
`ifdef FFT_SEQ_CYCLE_CNT_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [11:0] tw;
        logic        bank;
        logic        stg;
    } ev_t;

    ev_t rd_q[$];
    ev_t wr_q[$];
    int  done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // Address model: lane j of a strided set is n+4j, of a block set 4n+j.
    function automatic logic [15:0] model_addr(input bit strided, input int n);
        logic [15:0] a;
        for (int j = 0; j < 4; j++)
            a[j*4 +: 4] = strided ? 4'(n + 4*j) : 4'(4*n + j);
        return a;
    endfunction

    function automatic logic [11:0] model_tw(input bit stg, input int n);
        logic [11:0] t;
        for (int j = 0; j < 3; j++) t[j*4 +: 4] = stg ? 4'(n * (j + 1)) : 4'd0;
        return t;
    endfunction

    task automatic push_rd(input int c, input bit stg, input int n);
        ev_t e;
        e.cyc = c; e.addr = model_addr(!stg, n); e.tw = model_tw(stg, n);
        e.bank = stg; e.stg = stg;
        rd_q.push_back(e);
    endtask

    task automatic push_wr(input int c, input bit stg, input int n);
        ev_t e;
        e.cyc = c; e.addr = model_addr(stg, n); e.tw = '0;
        e.bank = !stg; e.stg = stg;
        wr_q.push_back(e);
    endtask

    // Monitor: compares every presented read, write and done pulse.
    always @(negedge clk) begin
        ev_t e;
        int  rel;
        rel = cyc - t0;
        if (rd_en === 1'b1) begin
            if (rd_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rd_unexpected: got rd_en=1 rd_addr=%0h at cycle %0d, required none", rd_addr, rel);
            end else begin
                e = rd_q.pop_front();
                check("rd_cycle", rel, e.cyc);
                check("rd_addr", rd_addr, e.addr);
                check("tw_idx", tw_idx, e.tw);
                check("rd_bank", rd_bank, e.bank);
                check("stage", stage, e.stg);
            end
        end
        if (wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL wr_unexpected: got wr_en=1 wr_addr=%0h at cycle %0d, required none", wr_addr, rel);
            end else begin
                e = wr_q.pop_front();
                check("wr_cycle", rel, e.cyc);
                check("wr_addr", wr_addr, e.addr);
                check("wr_bank", wr_bank, e.bank);
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL done_unexpected: got done=1 at cycle %0d, required none", rel);
            end else begin
                check("done_cycle", rel, done_q.pop_front());
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_rel(input int r);
        while (cyc - t0 < r) tick();
    endtask

    task automatic start_run();
        tick();
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_drained(input int budget);
        int k = 0;
        while ((rd_q.size() + wr_q.size() + done_q.size()) != 0 && k < budget) begin
            tick();
            k++;
        end
        check("events_pending", rd_q.size() + wr_q.size() + done_q.size(), 0);
        rd_q.delete(); wr_q.delete(); done_q.delete();
        tick();
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_rd_bank"}, rd_bank, 0);
        check({tag, "_tw_idx"}, tw_idx, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_bank"}, wr_bank, 0);
        check({tag, "_stage"}, stage, 0);
    endtask

    // Uninterrupted transform: reads 1-4 / 14-17, writes 10-13 / 23-26, done 27.
    task automatic run_full();
        for (int n = 0; n < 4; n++) push_rd(1 + n, 1'b0, n);
        for (int n = 0; n < 4; n++) push_rd(14 + n, 1'b1, n);
        for (int n = 0; n < 4; n++) push_wr(10 + n, 1'b0, n);
        for (int n = 0; n < 4; n++) push_wr(23 + n, 1'b1, n);
        done_q.push_back(27);
        start_run();
        wait_rel(17);
        check("s2n3_rd_addr", rd_addr, 16'hFEDC);
        check("s2n3_tw_idx", tw_idx, 12'h963);
        wait_rel(18);
        check("rd_addr_held", rd_addr, 16'hFEDC);
        check("tw_idx_held", tw_idx, 12'h963);
        wait_rel(26);
        check("s2n3_wr_addr", wr_addr, 16'hFB73);
        check("s2n3_wr_bank", wr_bank, 0);
        wait_drained(60);
`ifdef FFT_SEQ_CYCLE_CNT_EN
        tick(); tick();
        check("cycle_cnt", cycle_cnt, 27);
        repeat (5) tick();
        check("cycle_cnt_held", cycle_cnt, 27);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;

        // hold in IDLE must not trigger any issue (monitor flags any rd_en).
        hold = 1'b1;
        repeat (4) tick();
        hold = 1'b0;

        // Plain transform.
        run_full();

        // hold in cycles 2-3 and a second start in cycle 5 that must be ignored.
        push_rd(1, 1'b0, 0); push_rd(4, 1'b0, 1); push_rd(5, 1'b0, 2); push_rd(6, 1'b0, 3);
        for (int n = 0; n < 4; n++) push_rd(16 + n, 1'b1, n);
        push_wr(10, 1'b0, 0); push_wr(13, 1'b0, 1); push_wr(14, 1'b0, 2); push_wr(15, 1'b0, 3);
        for (int n = 0; n < 4; n++) push_wr(25 + n, 1'b1, n);
        done_q.push_back(29);
        start_run();
        wait_rel(2);  hold  = 1'b1;
        wait_rel(4);  hold  = 1'b0;
        wait_rel(5);  start = 1'b1;
        wait_rel(6);  start = 1'b0;
        wait_drained(60);
        repeat (10) tick();

        // Reset in cycle 12 aborts the transform; no writes afterwards.
        for (int n = 0; n < 4; n++) push_rd(1 + n, 1'b0, n);
        for (int n = 0; n < 3; n++) push_wr(10 + n, 1'b0, n);
        start_run();
        wait_rel(12); rst = 1'b1;
        wait_rel(13); rst = 1'b0;
        check_all_zero("midrst");
        check("midrst_pending", rd_q.size() + wr_q.size(), 0);
        repeat (20) tick();

        // A full transform still runs after the abort.
        run_full();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
